// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - program store that replays 6-bit instructions into the core, one per clock
// Optional build macro: INSTR_FEEDER_LOOP_EN (continuous wrap-around replay).
module instr_feeder #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [5:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [5:0] instr,
    output logic       busy,
    output logic       done,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rptr;
    logic [5:0]      mem [DEPTH];

    logic [CW-1:0]   count_m1;
    logic [AW-1:0]   last_pos;
    logic [AW-1:0]   cur_pos;
    logic            do_load;
    logic            do_write;

    assign full     = (count == CW'(DEPTH));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // rptr always points one past the instruction currently on instr
    assign count_m1 = count - CW'(1);
    assign last_pos = count_m1[AW-1:0];
    assign cur_pos  = rptr - AW'(1);

    assign do_load  = (state != RUN) && start && !clear && (count != '0);
    assign do_write = !rst && (state == IDLE) && wr_en && !start && !clear && !full;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            rptr  <= '0;
            instr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (clear) begin
                        count <= '0;
                        state <= IDLE;
                        instr <= '0;
                    end else if (do_load) begin
                        instr <= mem[0];
                        rptr  <= AW'(1);
                        state <= RUN;
                    end else if (do_write) begin
                        count <= count + CW'(1);
                    end
                end
                RUN: begin
                    if (clear) begin
                        count <= '0;
                        state <= IDLE;
                        instr <= '0;
                    end else if (stop) begin
                        state <= DONE;
                        instr <= '0;
                    end else if (cur_pos == last_pos) begin
`ifdef INSTR_FEEDER_LOOP_EN
                        instr <= mem[0];
                        rptr  <= AW'(1);
`else
                        state <= DONE;
                        instr <= '0;
`endif
                    end else begin
                        instr <= mem[rptr];
                        rptr  <= rptr + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    instr <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - scoreboard bench for instr_feeder with directed programs
module tb_instr_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [5:0] wr_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] instr;
    logic       busy;
    logic       done;
    logic       full;

    typedef struct packed {
        logic [5:0] instr;
        logic       busy;
        logic       done;
        logic       full;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    instr_feeder #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .stop(stop), .clear(clear),
        .instr(instr), .busy(busy), .done(done), .full(full)
    );

    always #5 clk = ~clk;

    // Expected outputs are queued at the edge; the monitor checks them half a cycle later.
    task automatic tick(input string nm, input logic [5:0] ei, input logic eb,
                        input logic ed, input logic ef);
        exp_t e;
        @(posedge clk);
        e.instr = ei; e.busy = eb; e.done = ed; e.full = ef;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic wr(input string nm, input logic [5:0] d, input logic ef);
        wr_en = 1'b1;
        wr_data = d;
        tick(nm, 6'h00, 1'b0, 1'b0, ef);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if ({instr, busy, done, full} !== e) begin
                n_bad++;
                $display("FAIL %s: got instr=%h busy=%b done=%b full=%b, want instr=%h busy=%b done=%b full=%b",
                         nm, instr, busy, done, full, e.instr, e.busy, e.done, e.full);
            end
        end
    end

    initial begin
        logic [5:0] prog8 [8];
        int waited;
        prog8 = '{6'h0A, 6'h15, 6'h20, 6'h2B, 6'h36, 6'h01, 6'h0C, 6'h17};

        tick("reset0", 6'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick("reset1", 6'h00, 1'b0, 1'b0, 1'b0);

        // three-instruction single pass
        wr("w05", 6'h05, 1'b0);
        wr("w2a", 6'h2A, 1'b0);
        wr("w11", 6'h11, 1'b0);
        start = 1'b1;
        tick("run0", 6'h05, 1'b1, 1'b0, 1'b0);
        tick("run1", 6'h2A, 1'b1, 1'b0, 1'b0);
        tick("run2", 6'h11, 1'b1, 1'b0, 1'b0);
        tick("done0", 6'h00, 1'b0, 1'b1, 1'b0);
        wr_en = 1'b1; wr_data = 6'h3F;
        tick("done_wr_ign", 6'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        tick("rerun0", 6'h05, 1'b1, 1'b0, 1'b0);
        tick("rerun1", 6'h2A, 1'b1, 1'b0, 1'b0);
        tick("rerun2", 6'h11, 1'b1, 1'b0, 1'b0);
        tick("redone", 6'h00, 1'b0, 1'b1, 1'b0);
        clear = 1'b1;
        tick("clear0", 6'h00, 1'b0, 1'b0, 1'b0);

        // fill to DEPTH, overflow write dropped
        for (int i = 0; i < 8; i++) wr($sformatf("fill%0d", i), prog8[i], (i == 7));
        wr("overflow", 6'h3F, 1'b1);
        start = 1'b1;
        for (int i = 0; i < 8; i++) tick($sformatf("full_run%0d", i), prog8[i], 1'b1, 1'b0, 1'b1);
        tick("full_done", 6'h00, 1'b0, 1'b1, 1'b1);
        clear = 1'b1;
        tick("clear1", 6'h00, 1'b0, 1'b0, 1'b0);

        // empty start ignored
        start = 1'b1;
        tick("empty_start", 6'h00, 1'b0, 1'b0, 1'b0);
        tick("empty_idle", 6'h00, 1'b0, 1'b0, 1'b0);

        // stop in the second RUN cycle
        for (int i = 1; i <= 4; i++) wr($sformatf("w4_%0d", i), 6'(i), 1'b0);
        start = 1'b1;
        tick("stop_run0", 6'h01, 1'b1, 1'b0, 1'b0);
        tick("stop_run1", 6'h02, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick("stop_done", 6'h00, 1'b0, 1'b1, 1'b0);
        tick("stop_hold", 6'h00, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        tick("restart0", 6'h01, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick("run_clear", 6'h00, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick("clr_start", 6'h00, 1'b0, 1'b0, 1'b0);

        // two-entry program: loop or single pass
        wr("w07", 6'h07, 1'b0);
        wr("w08", 6'h08, 1'b0);
        start = 1'b1;
        tick("p2_0", 6'h07, 1'b1, 1'b0, 1'b0);
        tick("p2_1", 6'h08, 1'b1, 1'b0, 1'b0);
`ifdef INSTR_FEEDER_LOOP_EN
        tick("loop_2", 6'h07, 1'b1, 1'b0, 1'b0);
        tick("loop_3", 6'h08, 1'b1, 1'b0, 1'b0);
        tick("loop_4", 6'h07, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        tick("loop_stop", 6'h00, 1'b0, 1'b1, 1'b0);
`else
        tick("p2_done", 6'h00, 1'b0, 1'b1, 1'b0);
`endif
        clear = 1'b1;
        tick("clear2", 6'h00, 1'b0, 1'b0, 1'b0);

        // reset in the second RUN cycle
        wr("r05", 6'h05, 1'b0);
        wr("r2a", 6'h2A, 1'b0);
        wr("r11", 6'h11, 1'b0);
        start = 1'b1;
        tick("rst_run0", 6'h05, 1'b1, 1'b0, 1'b0);
        tick("rst_run1", 6'h2A, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick("rst_mid", 6'h00, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick("rst_start", 6'h00, 1'b0, 1'b0, 1'b0);
        tick("rst_idle", 6'h00, 1'b0, 1'b0, 1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
